m_unit_param: RTL and testbench

- Parametrised RV32M/RV64M multiply/divide coprocessor with controller and datapath in one block, attached to the core's PCPI port.
- Operands are latched at acceptance. Divide retires DIV_STEP quotient bits per cycle; multiply retires MUL_STEP multiplier bits per cycle.
- Special divide cases terminate early.
- The unit aborts cleanly if the core drops pcpi_valid mid-operation.

---
 rtl/m_unit_param.sv | 231 +++++++++++++++++++++++
 tb/tb_m_unit_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_unit_param.sv
// m_unit_param: RV32M/RV64M multiply/divide coprocessor on the PCPI port (shift-add multiply, restoring divide).
// Optional macro M_RESULT_REUSE_EN keeps the last full divide's results and answers a repeat of it in one cycle.
module m_unit_param #(
   parameter int XLEN     = 32,
   parameter int DIV_STEP = 1,
   parameter int MUL_STEP = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            pcpi_valid,
   input  logic [31:0]     pcpi_insn,
   input  logic [XLEN-1:0] pcpi_rs1,
   input  logic [XLEN-1:0] pcpi_rs2,
   output logic            pcpi_busy,
   output logic            pcpi_ready,
   output logic            pcpi_wr,
   output logic [XLEN-1:0] pcpi_rd
);
   localparam int MUL_CYCLES = XLEN / MUL_STEP;
   localparam int DIV_CYCLES = XLEN / DIV_STEP;
   localparam int CW         = $clog2(XLEN) + 1;
   localparam int MW         = XLEN + MUL_STEP;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t              state;
   logic [2:0]          funct3_q;
   logic                a_neg_q, b_neg_q;
   logic [XLEN-1:0]     op_a, op_b;
   logic [2*XLEN-1:0]   mul_acc;
   logic [XLEN-1:0]     div_q, div_r;
   logic [CW-1:0]       cnt;

   logic [2:0]          f3;
   logic                accept, a_signed, b_signed, a_neg, b_neg;
   logic                div_zero, div_ovf, div_small, div_early;
   logic [XLEN-1:0]     abs_a, abs_b, early_res;
   logic                unused_insn_bits;

   assign f3        = pcpi_insn[14:12];
   assign accept    = (state == IDLE) && pcpi_valid && (pcpi_insn[6:0] == 7'b0110011)
                      && (pcpi_insn[31:25] == 7'b0000001);
   assign a_signed  = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
   assign b_signed  = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
   assign a_neg     = a_signed & pcpi_rs1[XLEN-1];
   assign b_neg     = b_signed & pcpi_rs2[XLEN-1];
   assign abs_a     = a_neg ? -pcpi_rs1 : pcpi_rs1;
   assign abs_b     = b_neg ? -pcpi_rs2 : pcpi_rs2;
   assign div_zero  = (pcpi_rs2 == '0);
   assign div_ovf   = f3[2] && !f3[0] && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (pcpi_rs2 == '1);
   assign div_small = (abs_a < abs_b);
   assign div_early = div_zero || div_ovf || div_small;
   assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

   // f3[1] separates REM/REMU from DIV/DIVU for the early results
   always_comb begin
      early_res = '0;
      if (div_zero)
         early_res = f3[1] ? pcpi_rs1 : '1;
      else if (div_ovf)
         early_res = f3[1] ? '0 : pcpi_rs1;
      else
         early_res = f3[1] ? pcpi_rs1 : '0;
   end

`ifdef M_RESULT_REUSE_EN
   logic                reuse_valid, reuse_signed;
   logic [XLEN-1:0]     reuse_rs1, reuse_rs2, reuse_quot, reuse_rem;
   logic [XLEN-1:0]     rs1_q, rs2_q;
   logic                reuse_hit;

   assign reuse_hit = reuse_valid && (pcpi_rs1 == reuse_rs1) && (pcpi_rs2 == reuse_rs2)
                      && (reuse_signed == !f3[0]);
`endif

   // Multiply step: the high half absorbs |A| times the next MUL_STEP multiplier bits, then the pair shifts right
   logic [MW-1:0]          mul_sum;
   logic [2*XLEN+MUL_STEP-1:0] mul_wide;
   logic [2*XLEN-1:0]      mul_next, mul_fin;
   logic [XLEN-1:0]        mul_res;

   assign mul_sum  = {{MUL_STEP{1'b0}}, mul_acc[2*XLEN-1:XLEN]}
                     + (MW'(op_a) * MW'(mul_acc[MUL_STEP-1:0]));
   assign mul_wide = {mul_sum, mul_acc[XLEN-1:0]};
   assign mul_next = mul_wide[2*XLEN+MUL_STEP-1:MUL_STEP];
   assign mul_fin  = (a_neg_q ^ b_neg_q) ? -mul_next : mul_next;
   assign mul_res  = (funct3_q == 3'd0) ? mul_fin[XLEN-1:0] : mul_fin[2*XLEN-1:XLEN];

   // Restoring divide: DIV_STEP quotient bits per cycle through a widened partial remainder
   logic [XLEN+DIV_STEP-1:0] div_part;
   logic [XLEN-1:0]          div_quot, quot_fin, rem_fin;

   always_comb begin
      div_part = {{DIV_STEP{1'b0}}, div_r};
      div_quot = div_q;
      for (int i = 0; i < DIV_STEP; i++) begin
         div_part = {div_part[XLEN+DIV_STEP-2:0], div_quot[XLEN-1]};
         div_quot = {div_quot[XLEN-2:0], 1'b0};
         if (div_part >= {{DIV_STEP{1'b0}}, op_b}) begin
            div_part    = div_part - {{DIV_STEP{1'b0}}, op_b};
            div_quot[0] = 1'b1;
         end
      end
   end

   assign quot_fin = (a_neg_q ^ b_neg_q) ? -div_quot : div_quot;
   assign rem_fin  = a_neg_q ? -div_part[XLEN-1:0] : div_part[XLEN-1:0];

   // Controller and datapath; outputs are registered so they are clean for exactly the DONE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         funct3_q   <= '0;
         a_neg_q    <= 1'b0;
         b_neg_q    <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         mul_acc    <= '0;
         div_q      <= '0;
         div_r      <= '0;
         cnt        <= '0;
         pcpi_busy  <= 1'b0;
         pcpi_ready <= 1'b0;
         pcpi_wr    <= 1'b0;
         pcpi_rd    <= '0;
`ifdef M_RESULT_REUSE_EN
         reuse_valid  <= 1'b0;
         reuse_signed <= 1'b0;
         reuse_rs1    <= '0;
         reuse_rs2    <= '0;
         reuse_quot   <= '0;
         reuse_rem    <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  funct3_q  <= f3;
                  a_neg_q   <= a_neg;
                  b_neg_q   <= b_neg;
                  op_a      <= abs_a;
                  op_b      <= abs_b;
                  cnt       <= '0;
                  pcpi_busy <= 1'b1;
`ifdef M_RESULT_REUSE_EN
                  rs1_q     <= pcpi_rs1;
                  rs2_q     <= pcpi_rs2;
`endif
                  if (!f3[2]) begin
                     state   <= MUL;
                     mul_acc <= {{XLEN{1'b0}}, abs_b};
`ifdef M_RESULT_REUSE_EN
                     reuse_valid <= 1'b0;
`endif
                  end else if (div_early) begin
                     state      <= DONE;
                     pcpi_ready <= 1'b1;
                     pcpi_wr    <= 1'b1;
                     pcpi_rd    <= early_res;
`ifdef M_RESULT_REUSE_EN
                  end else if (reuse_hit) begin
                     state      <= DONE;
                     pcpi_ready <= 1'b1;
                     pcpi_wr    <= 1'b1;
                     pcpi_rd    <= f3[1] ? reuse_rem : reuse_quot;
`endif
                  end else begin
                     state <= DIV;
                     div_q <= abs_a;
                     div_r <= '0;
                  end
               end
            end
            MUL: begin
               if (!pcpi_valid) begin
                  state     <= IDLE;
                  pcpi_busy <= 1'b0;
                  cnt       <= '0;
               end else begin
                  mul_acc <= mul_next;
                  cnt     <= cnt + CW'(1);
                  if (cnt == CW'(MUL_CYCLES - 1)) begin
                     state      <= DONE;
                     pcpi_ready <= 1'b1;
                     pcpi_wr    <= 1'b1;
                     pcpi_rd    <= mul_res;
                  end
               end
            end
            DIV: begin
               if (!pcpi_valid) begin
                  state     <= IDLE;
                  pcpi_busy <= 1'b0;
                  cnt       <= '0;
`ifdef M_RESULT_REUSE_EN
                  reuse_valid <= 1'b0;
`endif
               end else begin
                  div_q <= div_quot;
                  div_r <= div_part[XLEN-1:0];
                  cnt   <= cnt + CW'(1);
                  if (cnt == CW'(DIV_CYCLES - 1)) begin
                     state      <= DONE;
                     pcpi_ready <= 1'b1;
                     pcpi_wr    <= 1'b1;
                     pcpi_rd    <= funct3_q[1] ? rem_fin : quot_fin;
`ifdef M_RESULT_REUSE_EN
                     reuse_valid  <= 1'b1;
                     reuse_signed <= !funct3_q[0];
                     reuse_rs1    <= rs1_q;
                     reuse_rs2    <= rs2_q;
                     reuse_quot   <= quot_fin;
                     reuse_rem    <= rem_fin;
`endif
                  end
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               pcpi_busy  <= 1'b0;
               pcpi_ready <= 1'b0;
               pcpi_wr    <= 1'b0;
               pcpi_rd    <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_m_unit_param.sv
// tb_m_unit_param: randomized self-checking bench for m_unit_param (XLEN=32, DIV_STEP=1, MUL_STEP=8)
// against an arithmetic reference model; honours M_RESULT_REUSE_EN when defined.
module tb_m_unit_param;
   localparam int XLEN = 32;
`ifdef M_RESULT_REUSE_EN
   localparam bit REUSE = 1'b1;
`else
   localparam bit REUSE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            pcpi_valid;
   logic [31:0]     pcpi_insn;
   logic [XLEN-1:0] pcpi_rs1, pcpi_rs2;
   logic            pcpi_busy, pcpi_ready, pcpi_wr;
   logic [XLEN-1:0] pcpi_rd;

   int n_checks = 0;
   int n_fail   = 0;

   bit          model_reuse_valid = 1'b0;
   bit          model_reuse_signed;
   logic [31:0] model_reuse_a, model_reuse_b;

   m_unit_param #(.XLEN(XLEN), .DIV_STEP(1), .MUL_STEP(8)) dut (
      .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
      .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_busy(pcpi_busy),
      .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [31:0] make_insn(input logic [2:0] f3);
      return {7'b0000001, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), f3,
              5'($urandom_range(0, 31)), 7'b0110011};
   endfunction

   function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      logic [31:0] res;
      bit ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ub  = longint'({32'b0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      res = '0;
      case (f3)
         3'd0: begin p = sa * sb; res = p[31:0];  end
         3'd1: begin p = sa * sb; res = p[63:32]; end
         3'd2: begin p = sa * ub; res = p[63:32]; end
         3'd3: begin p = ua * ub; res = p[63:32]; end
         3'd4: if (b == 0) res = '1; else if (ovf) res = a; else begin p = sa / sb; res = p[31:0]; end
         3'd5: if (b == 0) res = '1; else res = a / b;
         3'd6: if (b == 0) res = a; else if (ovf) res = '0; else begin p = sa % sb; res = p[31:0]; end
         default: if (b == 0) res = a; else res = a % b;
      endcase
      return res;
   endfunction

   function automatic bit ref_early(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bit sgn;
      longint ma, mb;
      if (!f3[2]) return 1'b0;
      sgn = !f3[0];
      if (b == 0) return 1'b1;
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
      ma = longint'({32'b0, a});
      mb = longint'({32'b0, b});
      if (sgn && a[31]) ma = -longint'($signed(a));
      if (sgn && b[31]) mb = -longint'($signed(b));
      return ma < mb;
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return XLEN / 8 + 1;
      if (ref_early(f3, a, b)) return 1;
      if (REUSE && model_reuse_valid && a == model_reuse_a && b == model_reuse_b
          && model_reuse_signed == !f3[0]) return 1;
      return XLEN + 1;
   endfunction

   task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] exp_rd;
      int exp_lat, k;
      bit seen;
      exp_rd  = ref_result(f3, a, b);
      exp_lat = ref_latency(f3, a, b);
      @(negedge clk);
      pcpi_insn  = make_insn(f3);
      pcpi_rs1   = a;
      pcpi_rs2   = b;
      pcpi_valid = 1'b1;
      @(posedge clk);
      seen = 1'b0;
      k    = 0;
      while (!seen && k < 100) begin
         @(negedge clk);
         k++;
         if (k == 1) checkOutput({tag, ".busy"}, 64'(pcpi_busy), 64'd1);
         if (pcpi_ready) seen = 1'b1;
      end
      if (!seen) begin
         checkOutput({tag, ".timeout"}, 64'd0, 64'd1);
      end else begin
         checkOutput({tag, ".latency"}, 64'(k), 64'(exp_lat));
         checkOutput({tag, ".rd"}, 64'(pcpi_rd), 64'(exp_rd));
         checkOutput({tag, ".wr"}, 64'(pcpi_wr), 64'd1);
      end
      pcpi_valid = 1'b0;
      @(negedge clk);
      checkOutput({tag, ".idle"}, {pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd}, '0);
      if (!f3[2]) model_reuse_valid = 1'b0;
      else if (exp_lat == XLEN + 1) begin
         model_reuse_valid  = 1'b1;
         model_reuse_signed = !f3[0];
         model_reuse_a      = a;
         model_reuse_b      = b;
      end
   endtask

   task automatic applyAbort(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                             input int drop_k, input string tag);
      int ready_seen;
      ready_seen = 0;
      @(negedge clk);
      pcpi_insn  = make_insn(f3);
      pcpi_rs1   = a;
      pcpi_rs2   = b;
      pcpi_valid = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= drop_k; k++) begin
         @(negedge clk);
         ready_seen += int'(pcpi_ready);
      end
      checkOutput({tag, ".busy_before"}, 64'(pcpi_busy), 64'd1);
      pcpi_valid = 1'b0;
      @(negedge clk);
      ready_seen += int'(pcpi_ready);
      checkOutput({tag, ".busy_after"}, 64'(pcpi_busy), 64'd0);
      repeat (3) begin
         @(negedge clk);
         ready_seen += int'(pcpi_ready);
      end
      checkOutput({tag, ".no_ready"}, 64'(ready_seen), 64'd0);
      model_reuse_valid = 1'b0;
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'($urandom_range(0, 20));
         4: return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int ready_seen;
      logic [2:0]  f3;
      logic [31:0] a, b;
      reset      = 1'b1;
      pcpi_valid = 1'b0;
      pcpi_insn  = '0;
      pcpi_rs1   = '0;
      pcpi_rs2   = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset.outputs", {pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd}, '0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
      applyStimulus(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_max");
      applyStimulus(3'd4, -32'd20, 32'd3, "div_m20_3");
      applyStimulus(3'd6, -32'd20, 32'd3, "rem_m20_3");
      applyStimulus(3'd5, 32'd5, 32'd0, "divu_by_zero");
      applyStimulus(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow");
      applyStimulus(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      applyStimulus(3'd4, 32'd2, 32'd7, "div_small");

      applyAbort(3'd5, 32'd100, 32'd7, 11, "abort_divu");
      applyStimulus(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu_after_abort");

      @(negedge clk);
      pcpi_insn  = make_insn(3'd4);
      pcpi_rs1   = -32'd100;
      pcpi_rs2   = 32'd7;
      pcpi_valid = 1'b1;
      @(posedge clk);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("reset_mid_div", {pcpi_busy, pcpi_ready, pcpi_wr, pcpi_rd}, '0);
      pcpi_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      ready_seen = 0;
      repeat (40) begin
         @(negedge clk);
         ready_seen += int'(pcpi_ready);
      end
      checkOutput("reset_no_ready", 64'(ready_seen), 64'd0);
      model_reuse_valid = 1'b0;
      applyStimulus(3'd5, 32'd9, 32'd2, "divu_after_reset");

      applyStimulus(3'd4, 32'd100, 32'd7, "div_100_7");
      applyStimulus(3'd6, 32'd100, 32'd7, "rem_100_7_repeat");
      applyStimulus(3'd7, 32'd100, 32'd7, "remu_100_7_other_sign");

      @(negedge clk);
      pcpi_insn  = {7'b0000000, 5'd3, 5'd2, 3'd0, 5'd1, 7'b0110011};
      pcpi_valid = 1'b1;
      ready_seen = 0;
      repeat (6) begin
         @(negedge clk);
         ready_seen += int'(pcpi_ready) + int'(pcpi_busy);
      end
      checkOutput("non_m_ignored", 64'(ready_seen), 64'd0);
      pcpi_valid = 1'b0;

      for (int i = 0; i < 60; i++) begin
         f3 = 3'($urandom_range(0, 7));
         if (f3[2] && model_reuse_valid && $urandom_range(0, 3) == 0) begin
            a = model_reuse_a;
            b = model_reuse_b;
         end else begin
            a = pick_operand();
            b = pick_operand();
         end
         if ($urandom_range(0, 7) == 0 && ref_latency(f3, a, b) > 1)
            applyAbort(f3, a, b, $urandom_range(1, ref_latency(f3, a, b) - 1), "rand_abort");
         else
            applyStimulus(f3, a, b, "rand_op");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
